dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the pipelined CPU's data-memory port: accepts one load/store request at a time over a req/ready handshake.
- Inserts a parameterised number of wait states, then returns a single-cycle response (rvalid/rdata/err).
- Sits between the CPU's MEM-stage access logic and a word-organised RAM array, and models slow memory for stall/hazard work.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words in the array; legal word index 0..DEPTH_WORDS-1.
- LATENCY, 2, wait-state cycles between acceptance and response; legal range 0..15.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- req_i  input  1  request valid.
- we_i  input  1  1 = store, 0 = load.
- be_i  input  4  store byte enables; be_i[n] covers wdata_i[8n+7:8n]; ignored for loads.
- addr_i  input  32  byte address; word index = addr_i[31:2].
- wdata_i  input  32  store data.
- ready_o  output  1  responder can accept a request this cycle.
- rvalid_o  output  1  response valid, exactly one cycle per accepted request.
- rdata_o  output  32  load data; valid only while rvalid_o=1.
- err_o  output  1  access error; valid only while rvalid_o=1.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE; the wait counter is cleared.
  - ready_o=1, rvalid_o=0, rdata_o=0, err_o=0.
  - Array contents are not altered.
  - Reset dominates every other input in the same cycle.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: ready_o=1. On an edge with req_i=1, capture we_i, be_i, addr_i and wdata_i (acceptance edge E0).
    - If LATENCY=0, go to RESP.
    - Otherwise go to WAIT with counter = LATENCY-1.
  - WAIT: ready_o=0. Counter decrements each edge. When counter=0, the next edge goes to RESP.
  - RESP: ready_o=0, rvalid_o=1 for exactly one cycle, then IDLE.
- Timing:
  - rvalid_o is high in the cycle following edge E0+LATENCY.
  - ready_o returns high after edge E0+LATENCY+1.
  - Maximum throughput is one request per LATENCY+2 cycles.
- Requests while busy: req_i asserted while ready_o=0 is ignored, neither queued nor captured. If req_i is still high in IDLE, a new request is accepted at that edge.
- Errors:
  - An error is flagged when the captured addr[1:0] != 0 or word index >= DEPTH_WORDS.
  - On error: no array access, response err_o=1, rdata_o=0.
- Stores:
  - Committed at the edge entering RESP.
  - Only bytes with be=1 are updated; be=0000 is a legal no-op store.
  - Response has rdata_o=0, err_o=0.
- Loads:
  - The array is read at the edge entering RESP; rdata_o holds the full word.
  - A load issued after a store to the same word returns the post-store value.
- Output values outside RESP: rdata_o=0 and err_o=0 in IDLE and WAIT.
- Reset mid-transaction (in WAIT or RESP): the transaction is aborted, no response is produced, and a store still in WAIT is not committed.
- Arithmetic and counter width:
  - Word index is a comparison on the full addr[31:2]; no wrap-around. An address beyond the array is an error, not aliased.
  - Wait counter is 4 bits.

Test Plan:
- Reset then idle: rst_i=0 for 2 cycles, release -> ready_o=1, rvalid_o=0, rdata_o=0, err_o=0.
- Store then load, LATENCY=2:
  - Store addr=0x10, wdata=0xDEADBEEF, be=1111 at edge E0 -> rvalid_o=1 only in the cycle after E0+2, err_o=0, ready_o=1 after E0+3.
  - Load addr=0x10 -> rdata_o=0xDEADBEEF.
- Byte enables: word 0x10 holds 0xDEADBEEF; store wdata=0x11223344, be=0101 -> subsequent load returns 0xDE22BE44.
- Errors:
  - Load addr=0x13 -> rvalid_o=1, err_o=1, rdata_o=0.
  - Store to addr=0x200 (index 128) -> err_o=1; then a load of addr=0x0 returns the unchanged prior value.
- Busy-request handling: hold req_i=1 continuously for 3 back-to-back stores to 0x0, 0x4, 0x8 -> exactly 3 rvalid_o pulses spaced 4 cycles apart, and no request is captured during WAIT/RESP.
- Reset mid-operation: store 0xCAFEF00D to 0x20 (word previously 0), assert rst_i during WAIT -> no rvalid_o pulse; a load of 0x20 after reset returns 0.
- LATENCY=0 build: load accepted at E0 -> rvalid_o high in the cycle after E0; next request accepted at E0+2.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over req/ready, LATENCY wait
// states, then a single-cycle rvalid/rdata/err response from a word-organised array.
`timescale 1ns/1ps
module dmem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1    = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic        LAT_ZERO  = (LATENCY == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        we_r;
  logic [3:0]  be_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] mem_r [DEPTH_WORDS];

  logic             acc_we_s;
  logic [3:0]       acc_be_s;
  logic [31:0]      acc_addr_s;
  logic [31:0]      acc_wdata_s;
  logic             go_resp_s;
  logic             acc_err_s;
  logic [IDX_W-1:0] acc_idx_s;
  logic [31:0]      resp_data_s;

  // Select the access that enters RESP this edge: live inputs when LATENCY=0, else the captured request.
  always_comb begin
    acc_we_s    = we_r;
    acc_be_s    = be_r;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    go_resp_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      acc_we_s    = we_i;
      acc_be_s    = be_i;
      acc_addr_s  = addr_i;
      acc_wdata_s = wdata_i;
      go_resp_s   = req_i & LAT_ZERO;
    end else begin
      go_resp_s   = (state_r == ST_WAIT) && (cnt_r == 4'd0);
    end
    acc_err_s   = (acc_addr_s[1:0] != 2'b00) || (acc_addr_s[31:2] >= DEPTH_IDX);
    acc_idx_s   = acc_addr_s[IDX_W+1:2];
    resp_data_s = (!acc_we_s && !acc_err_s) ? mem_r[acc_idx_s] : 32'd0;
  end

  // Array write port; contents survive reset, but a reset edge never commits a store.
  always_ff @(posedge clk_i) begin
    if (rst_i && go_resp_s && acc_we_s && !acc_err_s) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be_s[b]) begin
          mem_r[acc_idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      we_r     <= 1'b0;
      be_r     <= 4'd0;
      addr_r   <= 32'd0;
      wdata_r  <= 32'd0;
      ready_o  <= 1'b1;
      rvalid_o <= 1'b0;
      rdata_o  <= 32'd0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      rdata_o  <= 32'd0;
      err_o    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_i) begin
            we_r    <= we_i;
            be_r    <= be_i;
            addr_r  <= addr_i;
            wdata_r <= wdata_i;
            ready_o <= 1'b0;
            if (LAT_ZERO) begin
              state_r  <= ST_RESP;
              rvalid_o <= 1'b1;
              rdata_o  <= resp_data_s;
              err_o    <= acc_err_s;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= LAT_M1;
            end
          end else begin
            ready_o <= 1'b1;
          end
        end
        ST_WAIT: begin
          ready_o <= 1'b0;
          if (cnt_r == 4'd0) begin
            state_r  <= ST_RESP;
            rvalid_o <= 1'b1;
            rdata_o  <= resp_data_s;
            err_o    <= acc_err_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          ready_o <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed and random load/store traffic
// against an associative-array memory model, plus a LATENCY=0 instance.
`timescale 1ns/1ps
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_i, req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        ready_o, rvalid_o, err_o;
  logic [31:0] rdata_o;

  logic        req0, we0;
  logic [3:0]  be0;
  logic [31:0] addr0, wdata0;
  logic        ready0, rvalid0, err0;
  logic [31:0] rdata0;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [int];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o)
  );

  dmem_responder #(.DEPTH_WORDS(128), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req0), .we_i(we0), .be_i(be0),
    .addr_i(addr0), .wdata_i(wdata0), .ready_o(ready0), .rvalid_o(rvalid0),
    .rdata_o(rdata0), .err_o(err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic addr_is_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'd128);
  endfunction

  // One full transaction on the LATENCY=2 instance, checked against the model.
  task automatic txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rd);
    int n;
    int idx;
    logic exp_e;
    logic [31:0] exp_d;
    logic [31:0] w;
    check("ready_before_req", 32'(ready_o), 32'd1);
    req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
    tick();
    req_i = 1'b0; we_i = 1'b0; be_i = 4'd0; addr_i = 32'd0; wdata_i = 32'd0;
    n = 0;
    while (rvalid_o !== 1'b1 && n < 20) begin
      check("ready_low_while_busy", 32'(ready_o), 32'd0);
      tick();
      n++;
    end
    check("response_latency", 32'(n), 32'd2);
    exp_e = addr_is_err(addr);
    idx   = int'(addr >> 2);
    exp_d = 32'd0;
    if (!exp_e && !we) exp_d = model.exists(idx) ? model[idx] : 32'd0;
    if (!exp_e && we) begin
      w = model.exists(idx) ? model[idx] : 32'd0;
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
      model[idx] = w;
    end
    rd = rdata_o;
    check("resp_err", 32'(err_o), 32'(exp_e));
    check("resp_rdata", rdata_o, exp_d);
    check("ready_low_in_resp", 32'(ready_o), 32'd0);
    tick();
    check("rvalid_one_cycle", 32'(rvalid_o), 32'd0);
    check("ready_back", 32'(ready_o), 32'd1);
    check("idle_rdata_zero", rdata_o, 32'd0);
    check("idle_err_zero", 32'(err_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int pulses[$];
    int issued;
    int seen;
    logic [31:0] a;
    logic [31:0] junk;

    req0 = 1'b0; we0 = 1'b0; be0 = 4'd0; addr0 = 32'd0; wdata0 = 32'd0;
    req_i = 1'b1; we_i = 1'b0; be_i = 4'd0; addr_i = 32'd0; wdata_i = 32'd0;

    // Reset, with req held high to show reset dominates.
    rst_i = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    req_i = 1'b0;
    rst_i = 1'b1;
    tick();
    check("idle_ready", 32'(ready_o), 32'd1);
    check("idle_rvalid", 32'(rvalid_o), 32'd0);

    // Store then load, then byte-enable merge.
    txn(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, rd);
    txn(1'b0, 4'b0000, 32'h10, 32'h0, rd);
    check("load_after_store", rd, 32'hDEADBEEF);
    txn(1'b1, 4'b0101, 32'h10, 32'h11223344, rd);
    txn(1'b0, 4'b0000, 32'h10, 32'h0, rd);
    check("byte_enable_merge", rd, 32'hDE22BE44);

    // Errors: misaligned load, out-of-range store leaves memory intact.
    txn(1'b1, 4'b1111, 32'h0, 32'h01020304, rd);
    txn(1'b0, 4'b0000, 32'h13, 32'h0, rd);
    txn(1'b1, 4'b1111, 32'h200, 32'hFFFFFFFF, rd);
    txn(1'b0, 4'b0000, 32'h0, 32'h0, rd);
    check("oob_store_no_alias", rd, 32'h01020304);
    txn(1'b1, 4'b0000, 32'h0, 32'hFFFFFFFF, rd);
    txn(1'b0, 4'b0000, 32'h0, 32'h0, rd);
    check("be_zero_noop", rd, 32'h01020304);

    // Back-to-back stores with req held; busy-time junk must never be captured.
    txn(1'b1, 4'b1111, 32'h0C, 32'h0C0C0C0C, rd);
    issued = 0;
    for (int t = 0; t < 20; t++) begin
      if (rvalid_o === 1'b1) pulses.push_back(t);
      if (ready_o === 1'b1 && issued < 3) begin
        req_i = 1'b1; we_i = 1'b1; be_i = 4'hF;
        addr_i = 32'(issued * 4); wdata_i = 32'hB0000000 + 32'(issued);
        model[issued] = wdata_i;
        issued++;
      end else if (issued < 3 || ready_o !== 1'b1) begin
        req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = 32'h0C; wdata_i = 32'hBAD0BAD0;
      end else begin
        req_i = 1'b0; we_i = 1'b0; be_i = 4'd0; addr_i = 32'd0; wdata_i = 32'd0;
      end
      tick();
    end
    check("busy_pulse_count", 32'(pulses.size()), 32'd3);
    if (pulses.size() >= 3) begin
      check("busy_spacing_1", 32'(pulses[1] - pulses[0]), 32'd4);
      check("busy_spacing_2", 32'(pulses[2] - pulses[1]), 32'd4);
    end
    for (int w = 0; w < 4; w++) txn(1'b0, 4'b0000, 32'(w * 4), 32'h0, rd);

    // Reset during WAIT aborts the store and suppresses the response.
    txn(1'b1, 4'b1111, 32'h20, 32'h0, rd);
    req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = 32'h20; wdata_i = 32'hCAFEF00D;
    tick();
    req_i = 1'b0; we_i = 1'b0; be_i = 4'd0; addr_i = 32'd0; wdata_i = 32'd0;
    check("wait_ready_low", 32'(ready_o), 32'd0);
    rst_i = 1'b0;
    #1;
    check("async_rst_ready", 32'(ready_o), 32'd1);
    check("async_rst_rvalid", 32'(rvalid_o), 32'd0);
    tick(); tick();
    rst_i = 1'b1;
    seen = 0;
    for (int t = 0; t < 6; t++) begin
      if (rvalid_o === 1'b1) seen++;
      tick();
    end
    check("no_resp_after_abort", 32'(seen), 32'd0);
    txn(1'b0, 4'b0000, 32'h20, 32'h0, rd);
    check("aborted_store_dropped", rd, 32'h0);

    // Random traffic over words 0..15 with occasional illegal addresses.
    for (int w = 0; w < 16; w++) txn(1'b1, 4'b1111, 32'(w * 4), $urandom, rd);
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 9) == 0) begin
        junk = $urandom;
        a = junk[0] ? (a | 32'($urandom_range(1, 3))) : (32'h200 + (junk & 32'h0FFFFFFC));
      end
      txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, rd);
    end

    // LATENCY=0 instance: response the cycle after acceptance, next accept two edges later.
    check("lat0_ready_idle", 32'(ready0), 32'd1);
    req0 = 1'b1; we0 = 1'b1; be0 = 4'hF; addr0 = 32'h4; wdata0 = 32'hA5A50001;
    tick();
    check("lat0_store_rvalid", 32'(rvalid0), 32'd1);
    check("lat0_store_ready", 32'(ready0), 32'd0);
    check("lat0_store_err", 32'(err0), 32'd0);
    check("lat0_store_rdata", rdata0, 32'd0);
    we0 = 1'b0;
    tick();
    check("lat0_gap_rvalid", 32'(rvalid0), 32'd0);
    check("lat0_gap_ready", 32'(ready0), 32'd1);
    tick();
    check("lat0_load_rvalid", 32'(rvalid0), 32'd1);
    check("lat0_load_rdata", rdata0, 32'hA5A50001);
    req0 = 1'b0;
    tick();
    check("lat0_end_rvalid", 32'(rvalid0), 32'd0);
    check("lat0_end_ready", 32'(ready0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
